dmrs_zc_seq_ctrl: RTL and testbench

Sequencer for DMRS Zadoff-Chu base-sequence generation in the PUSCH DMRS chain. On `start` it drives the sequence length to the combinational N_zc prime lookup and captures the returned prime length. It then streams one phase index per sample, with cyclic extension, through a valid/ready handshake to the downstream complex-exponential/mapping stage. The phase recurrence uses only add and conditional-subtract, so no multiplier and no reciprocal are needed.

---
 rtl/dmrs_zc_seq_ctrl_if.sv | 27 ++
 rtl/dmrs_zc_seq_ctrl.sv | 119 +++++++++++
 tb/tb_dmrs_zc_seq_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmrs_zc_seq_ctrl_if.sv
// Request, N_zc lookup and phase-stream signals of the DMRS ZC sequencer.
// The slave view belongs to the sequencer; the master view belongs to its environment.
interface dmrs_zc_seq_ctrl_if;
    logic       start;
    logic [9:0] mzc_in;
    logic [9:0] q_in;
    logic [9:0] mzc_o;
    logic [9:0] nzc_i;
    logic       phase_valid;
    logic       phase_ready;
    logic [9:0] phase;
    logic [9:0] idx;
    logic       last;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, mzc_in, q_in, nzc_i, phase_ready,
        input  mzc_o, phase_valid, phase, idx, last, busy, done, err
    );

    modport slave (
        input  start, mzc_in, q_in, nzc_i, phase_ready,
        output mzc_o, phase_valid, phase, idx, last, busy, done, err
    );
endinterface

// File: rtl/dmrs_zc_seq_ctrl.sv
// DMRS Zadoff-Chu phase sequencer. It looks up the prime length N_zc and streams
// phases q*n(n+1)/2 mod N_zc with cyclic extension, using only add and conditional subtract.
module dmrs_zc_seq_ctrl (
    input  logic                     clk,
    input  logic                     rst,
    dmrs_zc_seq_ctrl_if.slave        bus
);
    localparam int unsigned LW = 10;
    localparam int unsigned SW = 11;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

    state_e        state_q;
    logic [LW-1:0] mzc_q, q_q, nzc_q;
    logic [LW-1:0] p_q, s_q, n_q, m_q;
    logic          valid_q, last_q, busy_q, done_q, err_q;

    logic [SW-1:0] p_sum, s_sum;
    logic [LW-1:0] p_d, s_d;
    logic          adv;

    // p and s stay below nzc, so one conditional subtract reduces each sum exactly
    always_comb begin
        p_sum = SW'(p_q) + SW'(s_q);
        s_sum = SW'(s_q) + SW'(q_q);
        p_d   = (p_sum >= SW'(nzc_q)) ? LW'(p_sum - SW'(nzc_q)) : LW'(p_sum);
        s_d   = (s_sum >= SW'(nzc_q)) ? LW'(s_sum - SW'(nzc_q)) : LW'(s_sum);
    end

    assign adv = valid_q && bus.phase_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mzc_q   <= '0;
            q_q     <= '0;
            nzc_q   <= '0;
            p_q     <= '0;
            s_q     <= '0;
            n_q     <= '0;
            m_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.mzc_in == 10'd0) begin
                            err_q <= 1'b1;
                        end else begin
                            mzc_q   <= bus.mzc_in;
                            q_q     <= bus.q_in;
                            busy_q  <= 1'b1;
                            state_q <= LOAD;
                        end
                    end
                end
                // mzc_o has been stable a full cycle, so the lookup result is settled
                LOAD: begin
                    nzc_q <= bus.nzc_i;
                    if ((q_q == 10'd0) || (q_q >= bus.nzc_i)) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        p_q     <= '0;
                        s_q     <= q_q;
                        n_q     <= '0;
                        m_q     <= '0;
                        valid_q <= 1'b1;
                        last_q  <= (mzc_q == 10'd1);
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (adv) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            m_q    <= m_q + 10'd1;
                            last_q <= ((m_q + 10'd1) == (mzc_q - 10'd1));
                            // cyclic extension restarts the recurrence at n = 0
                            if (n_q == (nzc_q - 10'd1)) begin
                                n_q <= '0;
                                p_q <= '0;
                                s_q <= q_q;
                            end else begin
                                n_q <= n_q + 10'd1;
                                p_q <= p_d;
                                s_q <= s_d;
                            end
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mzc_o       = mzc_q;
    assign bus.phase_valid = valid_q;
    assign bus.phase       = p_q;
    assign bus.idx         = m_q;
    assign bus.last        = last_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_dmrs_zc_seq_ctrl.sv
// Bench for dmrs_zc_seq_ctrl: a prime-lookup model plus a closed-form phase reference.
module tb_dmrs_zc_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmrs_zc_seq_ctrl_if bus();

    dmrs_zc_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int got_phase [0:1023];

    // Largest prime not exceeding m (0 when none exists)
    function automatic logic [9:0] largest_prime(input logic [9:0] m);
        bit pr;
        for (int c = int'(m); c >= 2; c--) begin
            pr = 1'b1;
            for (int d = 2; d * d <= c; d++)
                if (c % d == 0) pr = 1'b0;
            if (pr) return 10'(c);
        end
        return 10'd0;
    endfunction

    function automatic int ref_phase(input int q, input int nzc, input int m);
        longint n;
        n = longint'(m % nzc);
        return int'((longint'(q) * n * (n + 1) / 2) % longint'(nzc));
    endfunction

    always_comb bus.nzc_i = largest_prime(bus.mzc_o);

    // Streams one sequence; mode 0 = ready high, 1 = ready pattern 1,0,0,1, 2 = random ready.
    task automatic run_seq(input int mzc, input int q, input int mode, input int start_at,
                           output int stalls);
        int  nzc, m, budget, k, exp_p, t0, elapsed;
        bit  fin, rdy, exp_last;
        nzc = int'(largest_prime(10'(mzc)));
        m = 0; k = 0; fin = 1'b0; stalls = 0;
        @(negedge clk);
        t0 = int'($time / 10);
        bus.start = 1'b1; bus.mzc_in = 10'(mzc); bus.q_in = 10'(q); bus.phase_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        tests++;
        if (bus.busy !== 1'b1 || bus.phase_valid !== 1'b0 || bus.mzc_o !== 10'(mzc)) begin
            fails++;
            $display("FAIL load_state busy=%0b valid=%0b mzc_o=%0d want 1/0/%0d",
                     bus.busy, bus.phase_valid, bus.mzc_o, mzc);
        end
        @(negedge clk);
        tests++;
        if (bus.phase_valid !== 1'b1) begin
            fails++;
            $display("FAIL first_valid_latency valid=%0b want 1", bus.phase_valid);
        end
        budget = 4 * mzc + 50;
        while (!fin && budget > 0) begin
            budget--;
            bus.start = 1'b0;
            tests++;
            if (bus.phase_valid !== 1'b1) begin
                fails++;
                $display("FAIL valid_drop at m=%0d valid=%0b want 1", m, bus.phase_valid);
                break;
            end
            exp_p    = ref_phase(q, nzc, m);
            exp_last = (m == mzc - 1);
            if (bus.idx !== 10'(m) || bus.phase !== 10'(exp_p) || bus.last !== exp_last) begin
                fails++;
                $display("FAIL sample mzc=%0d q=%0d idx=%0d phase=%0d last=%0b want idx=%0d phase=%0d last=%0b",
                         mzc, q, bus.idx, bus.phase, bus.last, m, exp_p, exp_last);
            end
            got_phase[m] = int'(bus.phase);
            if (m == start_at) begin
                bus.start = 1'b1; bus.mzc_in = 10'd5; bus.q_in = 10'd2;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (k % 4 == 0) || (k % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            k++;
            bus.phase_ready = rdy;
            if (rdy) begin
                if (m == mzc - 1) fin = 1'b1;
                m++;
            end else begin
                stalls++;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.phase_ready = 1'b0;
        tests++;
        if (!fin) begin
            fails++;
            $display("FAIL seq_timeout mzc=%0d accepted=%0d want %0d", mzc, m, mzc);
        end
        tests++;
        elapsed = int'($time / 10) - t0;
        if (bus.done !== 1'b1 || bus.phase_valid !== 1'b0 || elapsed != 2 + mzc + stalls) begin
            fails++;
            $display("FAIL done_pulse done=%0b valid=%0b cycles=%0d want 1/0/%0d",
                     bus.done, bus.phase_valid, elapsed, 2 + mzc + stalls);
        end
        @(negedge clk);
        tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL done_exit done=%0b busy=%0b want 0/0", bus.done, bus.busy);
        end
    endtask

    task automatic check_idle_zero(input string name);
        tests++;
        if (bus.mzc_o !== 10'd0 || bus.phase_valid !== 1'b0 || bus.phase !== 10'd0 ||
            bus.idx !== 10'd0 || bus.last !== 1'b0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.err !== 1'b0) begin
            fails++;
            $display("FAIL %s mzc_o=%0d valid=%0b phase=%0d idx=%0d last=%0b busy=%0b done=%0b err=%0b want all 0",
                     name, bus.mzc_o, bus.phase_valid, bus.phase, bus.idx, bus.last,
                     bus.busy, bus.done, bus.err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_zero("reset_values");
        rst = 1'b0;
    endtask

    task automatic test_q1();
        int st;
        int exp_tab [12] = '{0, 1, 3, 6, 10, 15, 0, 0, 1, 3, 6, 10};
        int idx_tab [12] = '{0, 1, 2, 3, 4, 5, 30, 31, 32, 33, 34, 35};
        run_seq(36, 1, 0, -1, st);
        for (int i = 0; i < 12; i++) begin
            tests++;
            if (got_phase[idx_tab[i]] != exp_tab[i]) begin
                fails++;
                $display("FAIL q1_table idx=%0d phase=%0d want %0d",
                         idx_tab[i], got_phase[idx_tab[i]], exp_tab[i]);
            end
        end
    endtask

    task automatic test_q5();
        int st;
        int exp_tab [5] = '{0, 5, 15, 30, 19};
        run_seq(36, 5, 0, -1, st);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (got_phase[i] != exp_tab[i]) begin
                fails++;
                $display("FAIL q5_table idx=%0d phase=%0d want %0d", i, got_phase[i], exp_tab[i]);
            end
        end
    endtask

    task automatic test_stall();
        int st;
        run_seq(36, 5, 1, -1, st);
        tests++;
        if (st == 0) begin
            fails++;
            $display("FAIL stall_count stalls=%0d want >0", st);
        end
    endtask

    task automatic test_err(input int mzc, input int q);
        @(negedge clk);
        bus.start = 1'b1; bus.mzc_in = 10'(mzc); bus.q_in = 10'(q);
        @(negedge clk);
        bus.start = 1'b0;
        if (mzc != 0) begin
            tests++;
            if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
                fails++;
                $display("FAIL err_load mzc=%0d q=%0d err=%0b busy=%0b want 0/1",
                         mzc, q, bus.err, bus.busy);
            end
            @(negedge clk);
        end
        tests++;
        if (bus.err !== 1'b1 || bus.phase_valid !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL err_pulse mzc=%0d q=%0d err=%0b valid=%0b busy=%0b want 1/0/0",
                     mzc, q, bus.err, bus.phase_valid, bus.busy);
        end
        @(negedge clk);
        tests++;
        if (bus.err !== 1'b0 || bus.phase_valid !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL err_exit mzc=%0d q=%0d err=%0b valid=%0b busy=%0b want 0/0/0",
                     mzc, q, bus.err, bus.phase_valid, bus.busy);
        end
    endtask

    task automatic test_errors();
        test_err(36, 0);
        test_err(36, 31);
        test_err(0, 5);
    endtask

    task automatic test_reset_midrun();
        int budget, st;
        bit seen_done;
        @(negedge clk);
        bus.start = 1'b1; bus.mzc_in = 10'd36; bus.q_in = 10'd5; bus.phase_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        budget = 40;
        while (!(bus.phase_valid === 1'b1 && bus.idx === 10'd10) && budget > 0) begin
            budget--;
            @(negedge clk);
        end
        tests++;
        if (budget == 0) begin
            fails++;
            $display("FAIL reach_idx10 idx=%0d want 10", bus.idx);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("reset_midrun");
        seen_done = 1'b0;
        repeat (5) begin
            if (bus.done === 1'b1 || bus.phase_valid === 1'b1) seen_done = 1'b1;
            @(negedge clk);
        end
        tests++;
        if (seen_done) begin
            fails++;
            $display("FAIL post_reset_activity seen=%0b want 0", seen_done);
        end
        bus.phase_ready = 1'b0;
        run_seq(36, 5, 0, -1, st);
    endtask

    task automatic test_start_while_busy();
        int st;
        run_seq(36, 1, 0, 20, st);
    endtask

    task automatic test_long();
        int st;
        run_seq(600, 100, 0, -1, st);
        tests++;
        if (got_phase[599] != 0 || got_phase[598] != ref_phase(100, 599, 598)) begin
            fails++;
            $display("FAIL long_wrap p598=%0d p599=%0d want %0d/0",
                     got_phase[598], got_phase[599], ref_phase(100, 599, 598));
        end
    endtask

    task automatic test_random();
        int mzc, nzc, q, st;
        for (int i = 0; i < 6; i++) begin
            mzc = int'($urandom_range(2, 120));
            nzc = int'(largest_prime(10'(mzc)));
            q   = int'($urandom_range(1, nzc - 1));
            run_seq(mzc, q, 2, -1, st);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.mzc_in = '0;
        bus.q_in = '0;
        bus.phase_ready = 1'b0;
        test_reset();
        test_q1();
        test_q5();
        test_stall();
        test_errors();
        test_reset_midrun();
        test_start_while_busy();
        test_long();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
